regfile_mp_sb: RTL
==================

Name: regfile_mp_sb

Overview:
Parametrised multi-port integer register file for the RV32 core, the successor to the current single-write/dual-read file. It adds configurable read and write port counts, same-cycle write-to-read bypass, and a per-register pending (scoreboard) bit. The scoreboard lets the issue stage detect RAW hazards against in-flight long-latency producers (loads, MUL/DIV). It sits between decode/issue and the writeback stage.

Parameters:
XLEN, 32, data width in bits
NREGS, 32, number of architectural registers; must be a power of 2
NRD, 2, number of read ports
NWR, 2, number of write ports; higher port index has higher priority
BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads return stored value only

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  reset, asynchronous, active-high
rd_addr  in  NRD*AW  read addresses; port k uses bits [k*AW +: AW]; AW = clog2(NREGS)
rd_data  out  NRD*XLEN  read data, combinational
rd_busy  out  NRD  1 = register at rd_addr[k] has a pending producer not resolved this cycle
wr_en  in  NWR  per-port write enable
wr_addr  in  NWR*AW  write addresses
wr_data  in  NWR*XLEN  write data
iss_en  in  1  mark the destination register as pending (long-latency producer issued)
iss_addr  in  AW  destination register to mark
pend_vec  out  NREGS  raw pending bits; debug and perf counters

Behaviour:
- Reset (async, rst=1): all registers become 0 and all pending bits become 0, effective immediately, including mid-operation. rd_data then reads 0 for every address and rd_busy reads 0.
- x0: always reads 0. Writes to x0 are dropped. iss_en to x0 is ignored. pend_vec[0] is always 0.
- Write, posedge: for each address, the winning writer is the highest-index port with wr_en=1 and that address. Only the winner's data is stored. Non-target registers hold their value.
- Write latency: the stored value is visible via the array on the cycle after the edge.
- Bypass (BYPASS=1): if any enabled write port targets rd_addr[k] (nonzero) this cycle, rd_data[k] = the winning writer's wr_data, combinationally. Otherwise rd_data[k] = the array value. BYPASS=0 returns the array value only.
- Pending set: on posedge with iss_en=1 and iss_addr!=0, pend[iss_addr] becomes 1.
- Pending clear: on posedge, any enabled write to address a clears pend[a].
- Simultaneous set and clear on the same address: set wins, so pend stays 1 for the newly issued producer. The write data is still stored.
- rd_busy[k] = pend[rd_addr[k]] AND NOT(BYPASS AND a write to rd_addr[k] is present this cycle). With BYPASS=0, rd_busy ignores writes in flight.
- A write without a prior issue is legal (single-cycle ALU writeback). pend stays 0.
- Re-issue to an already pending register is legal. The bit stays 1 and is cleared by the next write.
- No combinational path from rd_addr to any state. Outputs depend only on current inputs and state.

Decomposition:
- Package rf_pkg: AW function (clog2), the X0 constant, and the winner-select function (priority search over write ports for a given address).
- One sub-module, rf_read_port: one address in; outputs data and busy. It performs the array lookup, the x0 mask, the bypass mux and the busy qualification. It is instantiated NRD times with a generate loop.
- Array and pending register stay in the top module.

Test Plan:
- Reset mid-stream: write x5=0xDEADBEEF, then assert rst asynchronously between edges -> rd_data for x5 is 0 before the next edge and pend_vec is 0.
- Write/read and x0: write x0=0x1234 and x7=0x55AA55AA, then read x0 and x7 -> 0 and 0x55AA55AA. pend_vec[0] stays 0 after iss_en to x0.
- Port priority: port0 writes x3=0x1, port1 writes x3=0x2 in the same cycle -> next cycle reads 0x2. With BYPASS=1 the same-cycle read also returns 0x2.
- Scoreboard: iss x9, then 3 idle cycles -> rd_busy=1 on a port reading x9. On the writeback cycle of x9=0xA5 -> rd_busy=0 and rd_data=0xA5 (bypassed). The next cycle pend_vec[9]=0.
- Set/clear collision: x4 pending, then in one cycle write x4=0x77 and iss x4 -> next cycle pend_vec[4]=1 and x4 reads 0x77.
- BYPASS=0 build: the same-cycle write to x6 while reading x6 -> old value returned and rd_busy follows pend only. The new value appears next cycle.

Source files
------------

// File: rtl/rf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rf_pkg
// Description : Shared sizing helpers and write-port winner selection for the
//               multi-port scoreboarded register file.
// Revision    : 1.0 - initial release
// ============================================================================
package rf_pkg;

    // Widest configuration the padded write-port buses can carry
    localparam int C_MAX_WR = 8;
    localparam int C_MAX_AW = 8;
    localparam int C_X0     = 0;

    function automatic int aw_of(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Highest-index enabled port targeting a wins; -1 when no port targets a.
    // Unused upper ports must be presented with en=0.
    function automatic int wr_winner(
        input logic [C_MAX_WR-1:0]          en,
        input logic [C_MAX_WR*C_MAX_AW-1:0] addrs,
        input logic [C_MAX_AW-1:0]          a
    );
        int win;
        win = -1;
        for (int i = 0; i < C_MAX_WR; i++) begin
            if (en[i] && (addrs[i*C_MAX_AW +: C_MAX_AW] == a)) begin
                win = i;
            end
        end
        return win;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rf_read_port.sv
`default_nettype none
// ============================================================================
// Module      : rf_read_port
// Description : One read port: array lookup, x0 mask, write bypass and
//               scoreboard busy qualification.
// Revision    : 1.0 - initial release
// ============================================================================
module rf_read_port
    import rf_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NWR    = 2,
    parameter int BYPASS = 1,
    localparam int AW    = aw_of(NREGS)
) (
    input  logic [AW-1:0]                addr,
    input  logic [NREGS*XLEN-1:0]        mem_flat,
    input  logic [NREGS-1:0]             pend,
    input  logic [C_MAX_WR-1:0]          wr_en_pad,
    input  logic [C_MAX_WR*C_MAX_AW-1:0] wr_addr_pad,
    input  logic [NWR*XLEN-1:0]          wr_data,
    output logic [XLEN-1:0]              data,
    output logic                         busy
);

    int              w_win;
    int              w_widx;
    logic            w_byp;
    logic [XLEN-1:0] w_stored;
    logic [XLEN-1:0] w_fwd;

    always_comb begin
        w_win    = wr_winner(wr_en_pad, wr_addr_pad, C_MAX_AW'(addr));
        w_byp    = (BYPASS != 0) && (addr != AW'(C_X0)) && (w_win >= 0);
        w_widx   = w_byp ? w_win : 0;
        w_stored = mem_flat[addr*XLEN +: XLEN];
        w_fwd    = w_byp ? wr_data[w_widx*XLEN +: XLEN] : w_stored;
        data     = (addr == AW'(C_X0)) ? '0 : w_fwd;
        // A producer resolving this cycle is no longer a hazard once forwarded
        busy     = pend[addr] && !w_byp;
    end

endmodule
`default_nettype wire

// File: rtl/regfile_mp_sb.sv
`default_nettype none
// ============================================================================
// Module      : regfile_mp_sb
// Description : Parametrised multi-port integer register file with same-cycle
//               bypass and a per-register pending (scoreboard) bit.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_mp_sb
    import rf_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NRD    = 2,
    parameter int NWR    = 2,
    parameter int BYPASS = 1,
    localparam int AW    = aw_of(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    input  logic                iss_en,
    input  logic [AW-1:0]       iss_addr,
    output logic [NREGS-1:0]    pend_vec
);

    logic [XLEN-1:0]              r_mem [NREGS];
    logic [NREGS-1:0]             r_pend;
    logic [NREGS*XLEN-1:0]        w_mem_flat;
    logic [C_MAX_WR-1:0]          w_wr_en_pad;
    logic [C_MAX_WR*C_MAX_AW-1:0] w_wr_addr_pad;
    logic [NREGS-1:0]             w_hit;
    int                           w_sel [NREGS];

    // Ports padded to the package-wide width so one winner function serves all
    always_comb begin
        w_wr_en_pad   = '0;
        w_wr_addr_pad = '0;
        for (int p = 0; p < NWR; p++) begin
            w_wr_en_pad[p]                      = wr_en[p];
            w_wr_addr_pad[p*C_MAX_AW +: AW]     = wr_addr[p*AW +: AW];
        end
    end

    always_comb begin
        w_mem_flat = '0;
        w_hit      = '0;
        for (int a = 0; a < NREGS; a++) begin
            w_mem_flat[a*XLEN +: XLEN] = r_mem[a];
            w_sel[a] = wr_winner(w_wr_en_pad, w_wr_addr_pad, C_MAX_AW'(a));
            w_hit[a] = (a != C_X0) && (w_sel[a] >= 0);
        end
    end

    // x0 is never updated after reset, so it stays zero and never pends
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int a = 0; a < NREGS; a++) begin
                r_mem[a] <= '0;
            end
            r_pend <= '0;
        end else begin
            for (int a = 1; a < NREGS; a++) begin
                if (w_hit[a]) begin
                    r_mem[a] <= wr_data[w_sel[a]*XLEN +: XLEN];
                end
                if (iss_en && (iss_addr == AW'(a))) begin
                    r_pend[a] <= 1'b1;
                end else if (w_hit[a]) begin
                    r_pend[a] <= 1'b0;
                end
            end
        end
    end

    assign pend_vec = r_pend;

    generate
        for (genvar k = 0; k < NRD; k++) begin : g_rd
            rf_read_port #(
                .XLEN   (XLEN),
                .NREGS  (NREGS),
                .NWR    (NWR),
                .BYPASS (BYPASS)
            ) u_rd (
                .addr        (rd_addr[k*AW +: AW]),
                .mem_flat    (w_mem_flat),
                .pend        (r_pend),
                .wr_en_pad   (w_wr_en_pad),
                .wr_addr_pad (w_wr_addr_pad),
                .wr_data     (wr_data),
                .data        (rd_data[k*XLEN +: XLEN]),
                .busy        (rd_busy[k])
            );
        end
    endgenerate

endmodule
`default_nettype wire
